// File: rtl/regfile_wb_scheduler.sv
// -----------------------------------------------------------------------------
// regfile_wb_scheduler
//
// Arbitrates the single write port of the 32x64 register file between two
// writeback sources. It also keeps a per-register busy scoreboard and drives
// the issue-stage stall for RAW/WAW hazards.
//   - ALU writeback: fixed latency, cannot be stalled, always wins the port.
//   - Memory writeback: valid/ready handshake, granted when the ALU is idle.
// X31 is hardwired zero. It is never marked busy and never causes a hazard.
//
// Optional feature (macro REGFILE_WB_STARVE_GUARD_EN):
//   Adds a starvation counter. Once the memory writeback has been refused for
//   STARVE_LIMIT consecutive cycles, issue bubbles are forced. The bubbles let
//   the ALU pipeline drain so that memory gets the port. Without the macro
//   there is no counter, and memory may wait indefinitely.
//
// Ports:
//   clk, reset (async, active-low)
//   issue_valid/issue_we/issue_rd/issue_rs1/issue_rs2 -> issue_stall
//   alu_wb_valid/alu_wb_rd/alu_wb_data                  ALU writeback
//   mem_wb_valid/mem_wb_rd/mem_wb_data -> mem_wb_ready  memory writeback
//   rf_RegWrite/rf_WriteRegister/rf_WriteData           regfile write port
//   busy_vec                                            scoreboard (bit 31 = 0)
// -----------------------------------------------------------------------------
module regfile_wb_scheduler
`ifdef REGFILE_WB_STARVE_GUARD_EN
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
)
`endif
(
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_we,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    output logic        issue_stall,
    input  logic        alu_wb_valid,
    input  logic [4:0]  alu_wb_rd,
    input  logic [63:0] alu_wb_data,
    input  logic        mem_wb_valid,
    input  logic [4:0]  mem_wb_rd,
    input  logic [63:0] mem_wb_data,
    output logic        mem_wb_ready,
    output logic        rf_RegWrite,
    output logic [4:0]  rf_WriteRegister,
    output logic [63:0] rf_WriteData,
    output logic [31:0] busy_vec
);

    logic [30:0] r_busy;
    logic [30:0] w_busy_next;
    logic [30:0] w_set;
    logic [31:0] w_busy_vec;
    logic [31:0] w_clear;
    logic [31:0] w_haz;
    logic        w_rf_we;
    logic [4:0]  w_rf_rd;
    logic [63:0] w_rf_data;
    logic        w_mem_grant;
    logic        w_raw;
    logic        w_waw;
    logic        w_stall;
    logic        w_do_issue;
    logic        w_starve_bubble;

    // Write-port grant: ALU has fixed priority because it cannot stall.
    always_comb begin
        w_rf_we     = 1'b0;
        w_rf_rd     = 5'd0;
        w_rf_data   = 64'd0;
        w_mem_grant = 1'b0;
        if (alu_wb_valid) begin
            w_rf_we   = 1'b1;
            w_rf_rd   = alu_wb_rd;
            w_rf_data = alu_wb_data;
        end else if (mem_wb_valid) begin
            w_rf_we     = 1'b1;
            w_rf_rd     = mem_wb_rd;
            w_rf_data   = mem_wb_data;
            w_mem_grant = 1'b1;
        end
    end

    assign w_busy_vec = {1'b0, r_busy};

    // Per-register clear and hazard terms. A register that is being written
    // this cycle is not a hazard, because the regfile forwards the write data
    // to its read ports in the same cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_reg
            if (gi == 31) begin : g_zero
                assign w_clear[gi] = 1'b0;
            end else begin : g_rw
                assign w_clear[gi] = w_rf_we & (w_rf_rd == 5'(gi));
                assign w_set[gi]   = w_do_issue & (issue_rd == 5'(gi));
            end
            assign w_haz[gi] = w_busy_vec[gi] & ~w_clear[gi];
        end
    endgenerate

    assign w_raw      = w_haz[issue_rs1] | w_haz[issue_rs2];
    assign w_waw      = issue_we & w_haz[issue_rd];
    assign w_stall    = issue_valid & (w_raw | w_waw | w_starve_bubble);
    assign w_do_issue = issue_valid & ~w_stall & issue_we & (issue_rd != 5'd31);

    // A set is applied after the clear, so that an issue which re-targets a
    // register in its writeback cycle keeps that register busy.
    assign w_busy_next = (r_busy & ~w_clear[30:0]) | w_set;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

`ifdef REGFILE_WB_STARVE_GUARD_EN
    localparam logic [CNT_W-1:0] LP_LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_starve_cnt;

    // Counts consecutive refused memory requests and saturates at the limit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve_cnt <= '0;
        end else if (mem_wb_valid & ~w_mem_grant) begin
            if (r_starve_cnt != LP_LIMIT) begin
                r_starve_cnt <= r_starve_cnt + 1'b1;
            end
        end else begin
            r_starve_cnt <= '0;
        end
    end

    assign w_starve_bubble = (r_starve_cnt == LP_LIMIT);
`else
    assign w_starve_bubble = 1'b0;
`endif

    // While reset is asserted, the write port and the handshake are held off
    // and issue is held.
    assign issue_stall      = ~reset | w_stall;
    assign mem_wb_ready     = reset & w_mem_grant;
    assign rf_RegWrite      = reset & w_rf_we;
    assign rf_WriteRegister = w_rf_rd;
    assign rf_WriteData     = w_rf_data;
    assign busy_vec         = w_busy_vec;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for regfile_wb_scheduler.
//
// A driver applies inputs just after each rising edge. It predicts the
// outputs for that cycle from a reference model of the scheduling rules and
// queues the prediction. A monitor on the falling edge pops each prediction
// and compares it with the DUT. The stimulus is a directed preamble that
// follows the test plan, followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_regfile_wb_scheduler;

`ifdef REGFILE_WB_STARVE_GUARD_EN
    localparam int STARVE_LIMIT = 4;
`endif

    typedef struct packed {
        logic        in_rst;
        logic        stall;
        logic        we;
        logic [4:0]  wr;
        logic [63:0] wd;
        logic        mrdy;
        logic [31:0] busy;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        issue_valid;
    logic        issue_we;
    logic [4:0]  issue_rd;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic        issue_stall;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_rd;
    logic [63:0] alu_wb_data;
    logic        mem_wb_valid;
    logic [4:0]  mem_wb_rd;
    logic [63:0] mem_wb_data;
    logic        mem_wb_ready;
    logic        rf_RegWrite;
    logic [4:0]  rf_WriteRegister;
    logic [63:0] rf_WriteData;
    logic [31:0] busy_vec;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_txn    = 0;

    // Reference model state: which registers have a write in flight, and how
    // many cycles in a row memory has been refused.
    bit [31:0]   busy_m = '0;
    int          refused_run = 0;

    regfile_wb_scheduler dut (
        .clk              (clk),
        .reset            (reset),
        .issue_valid      (issue_valid),
        .issue_we         (issue_we),
        .issue_rd         (issue_rd),
        .issue_rs1        (issue_rs1),
        .issue_rs2        (issue_rs2),
        .issue_stall      (issue_stall),
        .alu_wb_valid     (alu_wb_valid),
        .alu_wb_rd        (alu_wb_rd),
        .alu_wb_data      (alu_wb_data),
        .mem_wb_valid     (mem_wb_valid),
        .mem_wb_rd        (mem_wb_rd),
        .mem_wb_data      (mem_wb_data),
        .mem_wb_ready     (mem_wb_ready),
        .rf_RegWrite      (rf_RegWrite),
        .rf_WriteRegister (rf_WriteRegister),
        .rf_WriteData     (rf_WriteData),
        .busy_vec         (busy_vec)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s txn %0d: got 0x%0h, expected 0x%0h", name, n_txn, act, exp);
        end
    endtask

    // Monitor: compares one queued prediction on each falling edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_txn++;
                $display("txn %0d: rst=%0b stall=%0b we=%0b rd=%0d data=0x%0h mrdy=%0b busy=0x%08h",
                         n_txn, e.in_rst, issue_stall, rf_RegWrite, rf_WriteRegister,
                         rf_WriteData, mem_wb_ready, busy_vec);
                chk("issue_stall", 64'(issue_stall), 64'(e.stall));
                chk("rf_RegWrite", 64'(rf_RegWrite), 64'(e.we));
                chk("mem_wb_ready", 64'(mem_wb_ready), 64'(e.mrdy));
                chk("busy_vec", 64'(busy_vec), 64'(e.busy));
                if (!e.in_rst) begin
                    chk("rf_WriteRegister", 64'(rf_WriteRegister), 64'(e.wr));
                    chk("rf_WriteData", rf_WriteData, e.wd);
                end
            end
        end
    end

    // A source register is a hazard if it has a write in flight that is not
    // being written back this very cycle.
    function automatic bit haz(input logic [4:0] r, input bit wb, input logic [4:0] wr);
        return busy_m[r] && !(wb && wr == r);
    endfunction

    // Predict this cycle's outputs, advance the model across the coming edge,
    // then move to just after that edge.
    task automatic step();
        exp_t        e;
        bit          wb;
        logic [4:0]  wr;
        logic [63:0] wd;
        bit          mrdy;
        bit          bubble;
        e = '0;
        wb = 1'b0; wr = 5'd0; wd = 64'd0; mrdy = 1'b0; bubble = 1'b0;
        if (alu_wb_valid) begin
            wb = 1'b1; wr = alu_wb_rd; wd = alu_wb_data;
        end else if (mem_wb_valid) begin
            wb = 1'b1; wr = mem_wb_rd; wd = mem_wb_data; mrdy = 1'b1;
        end
`ifdef REGFILE_WB_STARVE_GUARD_EN
        bubble = (refused_run >= STARVE_LIMIT);
`endif
        if (!reset) begin
            e.in_rst = 1'b1;
            e.stall  = 1'b1;
            busy_m   = '0;
            refused_run = 0;
            mrdy     = 1'b0;
        end else begin
            e.stall = issue_valid && (haz(issue_rs1, wb, wr) || haz(issue_rs2, wb, wr) ||
                                      (issue_we && haz(issue_rd, wb, wr)) || bubble);
            e.we    = wb;
            e.wr    = wr;
            e.wd    = wd;
            e.mrdy  = mrdy;
        end
        e.busy = busy_m;
        exp_q.push_back(e);
        if (reset) begin
            if (wb && wr != 5'd31) busy_m[wr] = 1'b0;
            if (issue_valid && !e.stall && issue_we && issue_rd != 5'd31) busy_m[issue_rd] = 1'b1;
            refused_run = (mem_wb_valid && !mrdy) ? refused_run + 1 : 0;
        end
        @(posedge clk);
        #1;
        if (mrdy) mem_wb_valid = 1'b0;
    endtask

    task automatic set_issue(input bit v, input bit we, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2);
        issue_valid = v; issue_we = we; issue_rd = rd; issue_rs1 = rs1; issue_rs2 = rs2;
    endtask

    task automatic set_alu(input bit v, input logic [4:0] rd, input logic [63:0] d);
        alu_wb_valid = v; alu_wb_rd = rd; alu_wb_data = d;
    endtask

    task automatic set_mem(input logic [4:0] rd, input logic [63:0] d);
        mem_wb_valid = 1'b1; mem_wb_rd = rd; mem_wb_data = d;
    endtask

    function automatic logic [4:0] pick_reg();
        int unsigned k;
        k = $urandom_range(0, 8);
        return (k == 8) ? 5'd31 : 5'(k);
    endfunction

    initial begin : driver
        reset = 1'b0;
        set_issue(0, 0, 0, 0, 0);
        set_alu(0, 0, 64'd0);
        mem_wb_valid = 1'b0; mem_wb_rd = 5'd0; mem_wb_data = 64'd0;
        @(posedge clk);
        #1;
        step();
        step();
        reset = 1'b1;

        // Reset in the middle of traffic with X1 and X2 busy.
        set_issue(1, 1, 1, 0, 0);  step();
        set_issue(1, 1, 2, 0, 0);  step();
        set_issue(1, 1, 3, 0, 0);
        set_alu(1, 4, 64'h1234);
        reset = 1'b0;              step();
        set_alu(0, 0, 64'd0);      step();
        reset = 1'b1;
        set_issue(1, 0, 0, 1, 0);  step();

        // RAW on X5, released by its ALU writeback.
        set_issue(1, 1, 5, 0, 0);  step();
        set_issue(1, 0, 0, 5, 0);  step();
        step();
        set_alu(1, 5, 64'hDEAD);   step();
        set_alu(0, 0, 64'd0);
        set_issue(0, 0, 0, 0, 0);  step();

        // ALU and memory together: ALU first, memory next cycle.
        set_alu(1, 3, 64'hA1A1);
        set_mem(7, {$urandom, $urandom});
        step();
        set_alu(0, 0, 64'd0);      step();
        step();

        // X31 is never busy and never a hazard.
        set_issue(1, 1, 31, 0, 0);  step();
        set_issue(1, 0, 0, 31, 31); step();

        // Set wins over clear on X9.
        set_issue(1, 1, 9, 0, 0);   step();
        set_alu(1, 9, 64'h99);      step();
        set_alu(0, 0, 64'd0);
        set_issue(0, 0, 0, 0, 0);   step();
        set_alu(1, 9, 64'h98);      step();
        set_alu(0, 0, 64'd0);

        // Memory refused under continuous ALU writebacks.
        set_issue(1, 0, 0, 0, 0);
        set_mem(4, {$urandom, $urandom});
        for (int i = 0; i < 8; i++) begin
            set_alu(1, 0, 64'(i));
            step();
        end
        set_alu(0, 0, 64'd0);
        for (int i = 0; i < 3; i++) step();

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
            set_issue($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                      pick_reg(), pick_reg(), pick_reg());
            set_alu($urandom_range(0, 9) < 4, pick_reg(), {$urandom, $urandom});
            if (!mem_wb_valid && $urandom_range(0, 9) < 3)
                set_mem(pick_reg(), {$urandom, $urandom});
            step();
        end
        reset = 1'b1;
        set_issue(0, 0, 0, 0, 0);
        set_alu(0, 0, 64'd0);
        step();

        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d predictions left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
